// File: rtl/clk_div_multi_if.sv
// Bus bundle for clk_div_multi: run controls, configuration write port and
// the divided outputs. clk/rst_n are kept outside as plain ports.
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  // cfg_ch is at least one bit wide, even for a single-channel build
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] enable;
  logic              sync_clr;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_tc;
  logic              cfg_mode;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

  modport master (
    output enable, sync_clr, cfg_we, cfg_ch, cfg_tc, cfg_mode,
    input  clk_out, tick, pending
  );

  modport slave (
    input  enable, sync_clr, cfg_we, cfg_ch, cfg_tc, cfg_mode,
    output clk_out, tick, pending
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator.
// Each channel counts up to its active terminal count (tc) and emits a
// one-cycle tick at the terminal edge. clk_out either toggles there (mode 0,
// 50% duty, period 2*(tc+1)) or mirrors the tick (mode 1).
// New settings land in a per-channel shadow and only reach the active
// registers at a terminal edge, on disable or on sync_clr, so a running
// channel never sees its period change mid-way and clk_out cannot runt.
// The interface instance must be built with the same NUM_CH / CNT_W.
module clk_div_multi #(
  parameter int              NUM_CH       = 4,
  parameter int              CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_TC  = CNT_W'(9_999_999),
  parameter logic            DEFAULT_MODE = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  clk_div_multi_if.slave  if_bus
);

  logic [CNT_W-1:0]  r_cnt   [NUM_CH];
  logic [CNT_W-1:0]  r_tc    [NUM_CH];
  logic [CNT_W-1:0]  r_sh_tc [NUM_CH];
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_sh_mode;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_clk_out;
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] w_wr_sel;

  // Decode the configuration write; an out-of-range cfg_ch selects nothing.
  always_comb begin
    w_wr_sel = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_wr_sel[ch] = if_bus.cfg_we && (int'(if_bus.cfg_ch) == ch);
    end
  end

  // Per-channel counter, output generation and shadow/active config handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_cnt[ch]   <= '0;
        r_tc[ch]    <= DEFAULT_TC;
        r_sh_tc[ch] <= DEFAULT_TC;
      end
      r_mode    <= {NUM_CH{DEFAULT_MODE}};
      r_sh_mode <= {NUM_CH{DEFAULT_MODE}};
      r_pending <= '0;
      r_clk_out <= '0;
      r_tick    <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (if_bus.sync_clr || !if_bus.enable[ch]) begin
          // Idle/cleared: safe point to adopt any waiting shadow config.
          r_cnt[ch]     <= '0;
          r_clk_out[ch] <= 1'b0;
          r_tick[ch]    <= 1'b0;
          if (r_pending[ch]) begin
            r_tc[ch]      <= r_sh_tc[ch];
            r_mode[ch]    <= r_sh_mode[ch];
            r_pending[ch] <= 1'b0;
          end
        end else if (r_cnt[ch] == r_tc[ch]) begin
          r_cnt[ch]  <= '0;
          r_tick[ch] <= 1'b1;
          if (r_pending[ch]) begin
            r_tc[ch]      <= r_sh_tc[ch];
            r_mode[ch]    <= r_sh_mode[ch];
            r_pending[ch] <= 1'b0;
          end
          // A mode switch restarts clk_out from low so the new waveform
          // begins from a known phase.
          if (r_pending[ch] && (r_sh_mode[ch] != r_mode[ch])) begin
            r_clk_out[ch] <= 1'b0;
          end else if (r_mode[ch]) begin
            r_clk_out[ch] <= 1'b1;
          end else begin
            r_clk_out[ch] <= ~r_clk_out[ch];
          end
        end else begin
          r_cnt[ch]  <= r_cnt[ch] + CNT_W'(1);
          r_tick[ch] <= 1'b0;
          if (r_mode[ch]) begin
            r_clk_out[ch] <= 1'b0;
          end
        end

        // Placed last so a write on an apply edge re-arms pending with the
        // new shadow; the apply above used the pre-edge shadow/pending.
        if (w_wr_sel[ch]) begin
          r_sh_tc[ch]   <= if_bus.cfg_tc;
          r_sh_mode[ch] <= if_bus.cfg_mode;
          r_pending[ch] <= 1'b1;
        end
      end
    end
  end

  assign if_bus.clk_out = r_clk_out;
  assign if_bus.tick    = r_tick;
  assign if_bus.pending = r_pending;

endmodule
